// File: rtl/iterative_divider.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// iterative_divider
//   Multi-cycle restoring divider that produces one quotient bit per clock.
//   It divides signed (two's-complement) or unsigned operands by working on
//   magnitudes and then applying a sign fix-up. The execute stage stalls
//   while busy is high and takes the results when done pulses.
//
//   Timing: the accepting edge loads the operands. DATA_WIDTH CALC edges
//   follow, then one FINISH edge registers the results and raises done.
//   Done is high for one cycle, so the consumer captures it on the
//   DATA_WIDTH+2nd edge after the accept.
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous, active-high reset
//   in_start         request; accepted only when idle and not in the done cycle
//   in_signed        1 = two's-complement operands, 0 = unsigned
//   in_num           numerator (dividend)
//   in_den           denominator (divisor)
//   out_busy         high from the accept edge until done drops
//   out_done         one-cycle pulse; results valid
//   out_quot         quotient; held until the next op finishes
//   out_rem          remainder; held until the next op finishes
//   out_div_by_zero  divide-by-zero flag of the last op; held like out_quot
//
// State   | meaning
// --------+----------------------------------------------------------------
// IDLE    | waiting for in_start; also retires the done cycle
// CALC    | shift/trial-subtract, one quotient bit per edge
// FINISH  | sign fix-up / div-by-zero override, registers results, raises done
// ----------------------------------------------------------------------------
module iterative_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_start,
    input  logic                  in_signed,
    input  logic [DATA_WIDTH-1:0] in_num,
    input  logic [DATA_WIDTH-1:0] in_den,
    output logic                  out_busy,
    output logic                  out_done,
    output logic [DATA_WIDTH-1:0] out_quot,
    output logic [DATA_WIDTH-1:0] out_rem,
    output logic                  out_div_by_zero
);

    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                state;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] quot_acc;
    logic [DATA_WIDTH-1:0] rem_acc;
    logic [DATA_WIDTH-1:0] den_mag;
    logic [DATA_WIDTH-1:0] num_lat;
    logic                  sign_q;
    logic                  sign_r;
    logic                  dbz_lat;

    logic                  num_neg;
    logic                  den_neg;
    logic [DATA_WIDTH-1:0] num_mag_in;
    logic [DATA_WIDTH-1:0] den_mag_in;

    logic                  shift_top;
    logic [DATA_WIDTH-1:0] shift_low;
    logic                  borrow;
    logic [DATA_WIDTH-1:0] diff;
    logic                  restore;

    // Operand magnitudes. Negating MIN wraps to MIN, and MIN read as an
    // unsigned value is the correct magnitude.
    always_comb begin
        num_neg    = in_signed & in_num[DATA_WIDTH-1];
        den_neg    = in_signed & in_den[DATA_WIDTH-1];
        num_mag_in = num_neg ? (~in_num + 1'b1) : in_num;
        den_mag_in = den_neg ? (~in_den + 1'b1) : in_den;
    end

    // The shifted partial remainder is DATA_WIDTH+1 bits wide: {shift_top,
    // shift_low}. The trial subtract works on the low part and produces a
    // borrow-out. A set top bit means the value already exceeds any divisor,
    // so restore is chosen only when there is a borrow and the top bit is
    // clear. In the non-restore case the true difference is below den_mag,
    // so the DATA_WIDTH-bit diff is exact.
    always_comb begin
        shift_top      = rem_acc[DATA_WIDTH-1];
        shift_low      = {rem_acc[DATA_WIDTH-2:0], quot_acc[DATA_WIDTH-1]};
        {borrow, diff} = {1'b0, shift_low} - {1'b0, den_mag};
        restore        = borrow & ~shift_top;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            count           <= '0;
            quot_acc        <= '0;
            rem_acc         <= '0;
            den_mag         <= '0;
            num_lat         <= '0;
            sign_q          <= 1'b0;
            sign_r          <= 1'b0;
            dbz_lat         <= 1'b0;
            out_busy        <= 1'b0;
            out_done        <= 1'b0;
            out_quot        <= '0;
            out_rem         <= '0;
            out_div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (out_done) begin
                        // Done cycle: a start request here is ignored.
                        out_done <= 1'b0;
                        out_busy <= 1'b0;
                    end else if (in_start) begin
                        num_lat  <= in_num;
                        quot_acc <= num_mag_in;
                        rem_acc  <= '0;
                        den_mag  <= den_mag_in;
                        sign_q   <= num_neg ^ den_neg;
                        sign_r   <= num_neg;
                        dbz_lat  <= (in_den == '0);
                        count    <= CW'(DATA_WIDTH - 1);
                        out_busy <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    quot_acc <= {quot_acc[DATA_WIDTH-2:0], ~restore};
                    rem_acc  <= restore ? shift_low : diff;
                    count    <= count - 1'b1;
                    if (count == '0) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    if (dbz_lat) begin
                        out_quot <= '1;
                        out_rem  <= num_lat;
                    end else begin
                        out_quot <= sign_q ? (~quot_acc + 1'b1) : quot_acc;
                        out_rem  <= sign_r ? (~rem_acc + 1'b1) : rem_acc;
                    end
                    out_div_by_zero <= dbz_lat;
                    out_done        <= 1'b1;
                    state           <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_divider.sv
`timescale 1ns/1ps
module tb_iterative_divider;

    logic        clk;
    logic        rst;
    logic        in_start;
    logic        in_signed;
    logic [31:0] in_num;
    logic [31:0] in_den;
    logic        out_busy;
    logic        out_done;
    logic [31:0] out_quot;
    logic [31:0] out_rem;
    logic        out_div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    iterative_divider #(.DATA_WIDTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_start        (in_start),
        .in_signed       (in_signed),
        .in_num          (in_num),
        .in_den          (in_den),
        .out_busy        (out_busy),
        .out_done        (out_done),
        .out_quot        (out_quot),
        .out_rem         (out_rem),
        .out_div_by_zero (out_div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Wait for done after an accept edge. Returns the number of edges after
    // the accept at which done was first seen high (sampled #1 after the
    // edge), and whether busy stayed high the whole time.
    task automatic wait_done(output int edges, output logic busy_ok);
        edges   = 0;
        busy_ok = 1'b1;
        while (!out_done && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (!out_busy) busy_ok = 1'b0;
        end
    endtask

    // One divide: issue at a negedge, scramble the operands right after the
    // accept, check latency, results, and the drop of busy/done.
    task automatic do_op(input string tag, input logic sgn, input logic [31:0] n,
                         input logic [31:0] d, input logic [31:0] eq,
                         input logic [31:0] er, input logic edz);
        int   edges;
        logic busy_ok;
        @(negedge clk);
        in_start  = 1'b1;
        in_signed = sgn;
        in_num    = n;
        in_den    = d;
        @(posedge clk); #1;
        check({tag, " busy_after_accept"}, {31'b0, out_busy}, 32'd1);
        in_start  = 1'b0;
        in_signed = ~sgn;
        in_num    = ~n;
        in_den    = d ^ 32'h5;
        wait_done(edges, busy_ok);
        // Done is raised by edge E0+33 and captured on edge E0+34.
        check({tag, " latency"}, edges, 32'd33);
        check({tag, " busy_during_calc"}, {31'b0, busy_ok}, 32'd1);
        check({tag, " quot"}, out_quot, eq);
        check({tag, " rem"}, out_rem, er);
        check({tag, " div_by_zero"}, {31'b0, out_div_by_zero}, {31'b0, edz});
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, {31'b0, out_done}, 32'd0);
        check({tag, " busy_drop"}, {31'b0, out_busy}, 32'd0);
        check({tag, " quot_held"}, out_quot, eq);
    endtask

    initial begin : main
        int   edges;
        int   dones;
        logic busy_ok;

        rst       = 1'b1;
        in_start  = 1'b0;
        in_signed = 1'b0;
        in_num    = '0;
        in_den    = '0;
        #12;
        check("reset busy", {31'b0, out_busy}, 32'd0);
        check("reset done", {31'b0, out_done}, 32'd0);
        check("reset quot", out_quot, 32'd0);
        check("reset rem", out_rem, 32'd0);
        check("reset dbz", {31'b0, out_div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op("u100/7",      1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0);
        do_op("s-7/2",       1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        do_op("s7/-2",       1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0);
        do_op("s-7/-2",      1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0);
        do_op("s100/-7",     1'b1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0);
        do_op("sMIN/-1",     1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0);
        do_op("uMIN/max",    1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0);
        do_op("sMIN/1",      1'b1, 32'h80000000, 32'd1,        32'h80000000, 32'd0,        1'b0);
        do_op("umax/1",      1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0);
        do_op("u/0",         1'b0, 32'h12345678, 32'd0,        32'hFFFFFFFF, 32'h12345678, 1'b1);
        do_op("s/0",         1'b1, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF0, 1'b1);
        do_op("u5/9",        1'b0, 32'd5,        32'd9,        32'd0,        32'd5,        1'b0);

        // Start held high: the first op is accepted, requests during the
        // calculation and the done cycle are ignored, and the second op is
        // accepted one cycle after done drops.
        @(negedge clk);
        in_start  = 1'b1;
        in_signed = 1'b0;
        in_num    = 32'd1000;
        in_den    = 32'd10;
        @(posedge clk); #1;
        check("held accept_a", {31'b0, out_busy}, 32'd1);
        in_num = 32'hFFFFFFFF;
        in_den = 32'h10;
        wait_done(edges, busy_ok);
        check("held latency_a", edges, 32'd33);
        check("held busy_a", {31'b0, busy_ok}, 32'd1);
        check("held quot_a", out_quot, 32'd100);
        check("held rem_a", out_rem, 32'd0);
        @(posedge clk); #1;
        check("held gap_busy", {31'b0, out_busy}, 32'd0);
        check("held gap_done", {31'b0, out_done}, 32'd0);
        @(posedge clk); #1;
        check("held accept_b", {31'b0, out_busy}, 32'd1);
        in_start = 1'b0;
        wait_done(edges, busy_ok);
        check("held latency_b", edges, 32'd33);
        check("held quot_b", out_quot, 32'h0FFFFFFF);
        check("held rem_b", out_rem, 32'h0000000F);
        @(posedge clk); #1;
        check("held done_b_drop", {31'b0, out_done}, 32'd0);

        // Reset in the middle of a calculation aborts it.
        @(negedge clk);
        in_start  = 1'b1;
        in_signed = 1'b0;
        in_num    = 32'h12345678;
        in_den    = 32'd3;
        @(posedge clk); #1;
        in_start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort busy", {31'b0, out_busy}, 32'd0);
        check("abort done", {31'b0, out_done}, 32'd0);
        check("abort quot", out_quot, 32'd0);
        check("abort rem", out_rem, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_done) dones++;
        end
        check("abort no_done", dones, 32'd0);
        check("abort idle", {31'b0, out_busy}, 32'd0);
        do_op("post_rst", 1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'h0000000F, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
